// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory read port, redirect/halt
// control from execute, and the valid/ready instruction stream to decode.
interface fetch_stage_if;
  logic [14:0] imem_raddr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  modport master (
    output imem_raddr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_raddr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues one read per cycle and
// queues returned words with their PCs for decode; redirects flush.
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic         clk,
  input logic         rst_n,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fq_t;

  fq_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   fetch_pc;
  logic [15:0]   inflight_pc;
  logic          inflight;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW-1:0] occ;
  fq_t           head;

  assign bus.out_valid = (count != '0);
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = rst_n & inflight & ~bus.redirect_valid;

  // count+inflight never exceeds DEPTH, so occ fits in CW bits
  assign occ   = count + CW'(inflight) - CW'(pop);
  assign issue = rst_n & ~bus.halt & ~bus.redirect_valid
               & (occ < DEPTH_C);

  assign bus.imem_raddr = fetch_pc[15:1];

  assign head          = mem[rd_ptr];
  assign bus.out_instr = bus.out_valid ? head.instr : 16'h0000;
  assign bus.out_pc    = bus.out_valid ? head.pc    : 16'h0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[15:1], 1'b0};
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 16'd2;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: inflight_pc};
  end

  ovf_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == DEPTH_C));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory word[n] = 16'h1000 + n,
// cycle-exact checks of the decode-side stream.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_stage_if bus ();

  fetch_stage #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bus.imem_rdata <= 16'h1000 + 16'(bus.imem_raddr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc);
    chk({tag, ".v"},  32'(bus.out_valid), 32'd1);
    chk({tag, ".pc"}, 32'(bus.out_pc), 32'(pc));
    chk({tag, ".in"}, 32'(bus.out_instr), 32'(16'h1000 + {1'b0, pc[15:1]}));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".v"},  32'(bus.out_valid), 32'd0);
    chk({tag, ".pc"}, 32'(bus.out_pc), 32'd0);
    chk({tag, ".in"}, 32'(bus.out_instr), 32'd0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    bus.out_ready      = 1'b1;

    // startup
    repeat (3) step();
    chk_empty("rst");
    chk("rst.raddr", 32'(bus.imem_raddr), 32'd0);
    rst_n = 1'b1;
    step();
    chk_empty("e0");
    for (int k = 0; k < 5; k++) begin
      step();
      chk_head($sformatf("strm%0d", k), 16'(2 * k));
    end

    // reset mid-stream, then backpressure from the start
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk_empty("mrst");
    rst_n = 1'b1;
    repeat (10) step();
    chk_head("bp.full", 16'h0000);
    chk("bp.raddr", 32'(bus.imem_raddr), 32'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_head($sformatf("bp%0d", k), 16'(2 + 2 * k));
    end

    // redirect with read in flight and queued words
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0041;
    step();
    chk_empty("rd.g0");
    chk("rd.raddr", 32'(bus.imem_raddr), 32'h20);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    step();
    chk_empty("rd.g1");
    step();
    chk_head("rd.g2", 16'h0040);
    step();
    chk_head("rd.g3", 16'h0042);

    // redirect with handshake same cycle, target wraps
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFC;
    step();
    chk_empty("hs.h0");
    bus.redirect_valid = 1'b0;
    step();
    chk_empty("hs.h1");
    step();
    chk_head("wr0", 16'hFFFC);
    step();
    chk_head("wr1", 16'hFFFE);
    step();
    chk_head("wr2", 16'h0000);
    step();
    chk_head("wr3", 16'h0002);

    // halt: one in-flight word lands, FIFO drains
    bus.halt = 1'b1;
    step();
    chk_head("ht0", 16'h0004);
    step();
    chk_empty("ht1");
    chk("ht.raddr", 32'(bus.imem_raddr), 32'd3);
    step();
    chk_empty("ht2");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0010;
    step();
    chk_empty("ht.rd");
    chk("ht.rdaddr", 32'(bus.imem_raddr), 32'd8);
    bus.redirect_valid = 1'b0;
    bus.halt           = 1'b0;
    step();
    chk_empty("ht.i4");
    step();
    chk_head("ht.i5", 16'h0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the decode/execute stage. It owns the fetch PC and issues one read per cycle on the instruction port of the unified memory. It buffers returned instruction words in a small FIFO and hands them, with their PCs, to decode over a valid/ready handshake. Taken jumps from execute arrive on a redirect input, which flushes the FIFO, discards any in-flight read and restarts fetch at the target.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2).
- RESET_PC, 16'h0000: fetch PC after reset (byte address, bit 0 = 0).

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- imem_raddr  out  15  word address, equal to fetch_pc[15:1]; memory returns imem_rdata one cycle later.
- imem_rdata  in  16  instruction word for the address presented on the previous cycle.
- redirect_valid  in  1  taken jump/branch from execute.
- redirect_pc  in  16  target byte address; bit 0 is ignored and forced to 0.
- halt  in  1  stop issuing new fetches while high.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  16  head instruction word; reads 0 when out_valid=0.
- out_pc  out  16  byte PC of the head instruction; reads 0 when out_valid=0.

## Operation
- State: fetch_pc[15:0], inflight (1 bit), inflight_pc[15:0], FIFO of {instr, pc} with count 0..DEPTH.
- pop = out_valid & out_ready.
- occ = count + inflight − pop.
- issue = rst_n & !halt & !redirect_valid & (occ < DEPTH).
- On issue:
  - inflight ← 1, inflight_pc ← fetch_pc.
  - fetch_pc ← fetch_pc + 2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
- Without issue: inflight ← 0, fetch_pc holds.
- Return: if inflight=1 and there is no redirect this cycle, push {imem_rdata, inflight_pc} into the FIFO.
- Push and pop may occur together; count is unchanged in that case.
- The occ rule guarantees a push never overflows the FIFO. An overflow is an assertion failure.
- Redirect has priority over everything:
  - A handshake in the same cycle still counts as consumed.
  - count ← 0, inflight ← 0, and any returning word is discarded.
  - fetch_pc ← {redirect_pc[15:1], 1'b0}.
  - No issue occurs that cycle; fetch resumes at the target on the next cycle if not halted.
- Halt:
  - Blocks issue only.
  - An in-flight read still lands and the FIFO still drains.
  - A redirect while halted updates fetch_pc and flushes.
- Reset (rst_n=0 at posedge):
  - fetch_pc ← RESET_PC, inflight ← 0, count ← 0.
  - out_valid=0, out_instr=0, out_pc=0.
  - Reset mid-operation drops all queued and in-flight words.
- imem_raddr is driven combinationally from fetch_pc at all times.
- The memory read has no side effects, so a non-issued address is harmless.

## Timing
- Edges are numbered E0, E1, … starting at the first posedge where rst_n=1.
- Startup:
  - E0 issues RESET_PC.
  - E1 pushes it; out_valid=1 after E1.
  - First-instruction latency from reset release is 2 edges.
- With out_ready=1 and no halt or redirect, throughput is one instruction per cycle at consecutive PCs.
- Redirect sampled at edge En: the target is issued at En+1, and the target instruction is at the FIFO head after En+2.
  - Redirect penalty is 2 cycles.
- out_valid, out_instr and out_pc are functions of registered FIFO state only.
  - There is no combinational path from out_ready or redirect_valid to any output.
- Backpressure: with out_ready=0 the FIFO fills to exactly DEPTH and issue stops.
  - A read issued before issue stops is still captured.
  - On the first pop after the FIFO is full, issue resumes the same cycle.

## Test plan
- Reset/startup:
  - Stimulus: rst_n low 3 cycles, then high, with memory word[n] = 16'h1000+n.
  - Required: out_valid rises after E1 with out_instr=16'h1000 and out_pc=0.
  - Required: with out_ready=1, successive outputs are 16'h1001/pc 2, 16'h1002/pc 4, …, one per cycle.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles, then 1.
  - Required: count saturates at 4 holding pcs 0,2,4,6, and no further reads are accepted.
  - Required: after release, pcs 8,10,… follow with no gap and no duplicates.
- Redirect with in-flight read:
  - Stimulus: streaming, then redirect_valid=1 with redirect_pc=16'h0041 for one cycle.
  - Required: the word in flight and all queued words are dropped.
  - Required: the next out_pc is 16'h0040, appearing 2 edges after the redirect.
  - Required: no instruction with pc > redirect point from the old stream appears.
- Redirect with handshake in the same cycle:
  - Required: the head is counted as consumed exactly once and is not re-presented.
  - Required: the FIFO is empty the next cycle.
- Wrap-around:
  - Stimulus: redirect to 16'hFFFC.
  - Required: outputs pcs FFFC, FFFE, 0000, 0002.
- Halt:
  - Stimulus: halt=1 mid-stream.
  - Required: exactly one in-flight word still lands and the FIFO drains, then out_valid=0.
  - Required: redirect to 16'h0010 while halted, then halt=0, produces next out_pc=16'h0010 two edges later.
